// File: rtl/idct_unit_if.sv
// rtl/idct_unit_if.sv - coefficient input / sample output bundle for one IDCT output lane
interface idct_if #(
   parameter int COEF_W = 12,
   parameter int OUT_W  = 12
);
   logic                     ena;
   logic                     dstrb;
   logic                     din_vld;
   logic signed [COEF_W-1:0] din;
   logic signed [OUT_W-1:0]  dout;
   logic                     dout_vld;
   logic                     busy;
   logic                     err;

   modport master (
      output ena, dstrb, din_vld, din,
      input  dout, dout_vld, busy, err
   );

   modport slave (
      input  ena, dstrb, din_vld, din,
      output dout, dout_vld, busy, err
   );
endinterface

// File: rtl/idct_unit.sv
// rtl/idct_unit.sv - one output lane f(X) of the 8-point 1-D inverse DCT
module idct_unit #(
   parameter int X       = 0,
   parameter int COEF_W  = 12,
   parameter int CONST_W = 12,
   parameter int OUT_W   = 12
) (
   input logic  clk,
   input logic  rst,
   idct_if.slave bus
);
   localparam int PROD_W = COEF_W + CONST_W;
   localparam int ACC_W  = PROD_W + 3;
   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] OUT_MIN = -ACC_W'(2 ** (OUT_W - 1));

   typedef enum logic {IDLE, ACC} state_t;

   state_t                    state, state_n;
   logic [2:0]                count, count_n, u;
   logic                      accept, take, first, last, viol;
   logic signed [CONST_W-1:0] coef;
   logic signed [PROD_W-1:0]  prod_d, prod;
   logic                      p_vld, p_first, p_last, a_last;
   logic signed [ACC_W-1:0]   acc, rnd;

   // cos((2X+1)u*pi/16) folded onto the first quadrant; X is fixed, so this is a constant table on u
   function automatic logic signed [CONST_W-1:0] cos_const(input logic [2:0] idx);
      int m;
      int mag;
      logic neg;
      m   = ((2 * X + 1) * int'(idx)) % 32;
      if (m > 16) m = 32 - m;
      neg = (m > 8);
      if (neg) m = 16 - m;
      mag = 0;
      case (m)
         0: mag = 1024;
         1: mag = 1004;
         2: mag = 946;
         3: mag = 851;
         4: mag = 724;
         5: mag = 569;
         6: mag = 392;
         7: mag = 200;
         default: mag = 0;
      endcase
      if (idx == 3'd0) begin
         mag = 724;
         neg = 1'b0;
      end
      return CONST_W'(neg ? -mag : mag);
   endfunction

   assign accept = bus.ena & bus.din_vld;
   assign coef   = cos_const(u);
   assign prod_d = bus.din * coef;
   assign rnd    = (acc + ACC_W'(1024)) >>> 11;
   assign bus.busy = (state == ACC);

   always_comb begin
      state_n = state;
      count_n = count;
      u       = count;
      take    = 1'b0;
      first   = 1'b0;
      last    = 1'b0;
      viol    = 1'b0;
      if (accept) begin
         if (bus.dstrb) begin
            // a strobe inside a vector drops the partial sum and restarts on this sample
            take    = 1'b1;
            first   = 1'b1;
            u       = 3'd0;
            count_n = 3'd1;
            state_n = ACC;
            viol    = (state == ACC);
         end else if (state == ACC) begin
            take    = 1'b1;
            count_n = count + 3'd1;
            if (count == 3'd7) begin
               last    = 1'b1;
               count_n = 3'd0;
               state_n = IDLE;
            end
         end else begin
            viol = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         count        <= 3'd0;
         bus.err      <= 1'b0;
         p_vld        <= 1'b0;
         p_first      <= 1'b0;
         p_last       <= 1'b0;
         prod         <= '0;
         acc          <= '0;
         a_last       <= 1'b0;
         bus.dout     <= '0;
         bus.dout_vld <= 1'b0;
      end else if (bus.ena) begin
         state        <= state_n;
         count        <= count_n;
         bus.err      <= viol;
         p_vld        <= take;
         p_first      <= first;
         p_last       <= last;
         prod         <= prod_d;
         if (p_vld) acc <= p_first ? ACC_W'(prod) : acc + ACC_W'(prod);
         a_last       <= p_vld & p_last;
         bus.dout_vld <= a_last;
         if (a_last) begin
            if (rnd > OUT_MAX)      bus.dout <= OUT_MAX[OUT_W-1:0];
            else if (rnd < OUT_MIN) bus.dout <= OUT_MIN[OUT_W-1:0];
            else                    bus.dout <= rnd[OUT_W-1:0];
         end
      end
   end
endmodule

// File: doc/idct_unit.md
Name: idct_unit

Overview:
- One output lane of the 1-D inverse DCT for the JPEG decode/loopback path; the inverse counterpart of the encoder's dct_unit.
- Accepts an 8-coefficient vector F(0..7) serially.
- Multiplies each coefficient by a fixed cosine constant selected by output index X, accumulates, rounds and saturates.
- Eight instances (X=0..7) form one idct_block, fed by a dequantiser.

Parameters:
- X, 0: output sample index 0..7; selects the constant set.
- COEF_W, 12: signed input coefficient width.
- CONST_W, 12: signed cosine constant width, scale 2^11.
- OUT_W, 12: signed output width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  clock enable; low freezes every register.
- dstrb  in  1  marks F(0), the first coefficient of a vector; qualified by din_vld.
- din_vld  in  1  din valid.
- din  in  COEF_W  signed coefficient F(u).
- dout  out  OUT_W  signed reconstructed sample f(X).
- dout_vld  out  1  one-cycle pulse, dout valid.
- busy  out  1  high while a vector is partially accepted.
- err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset: all registers cleared; dout=0, dout_vld=0, busy=0, err=0, state=IDLE, count=0.
- Reset is asynchronous and mid-operation: any partial vector is discarded and no dout_vld is issued for it.
- An input is accepted at a rising edge when ena=1 and din_vld=1. With ena=0, nothing changes and all outputs hold, including dout_vld.
- Constants: c(u) = round(2048 * C(u)/2 * cos((2X+1)*u*pi/16)), with C(0)=1/sqrt(2) and C(u>0)=1. For X=0: 724, 1004, 946, 851, 724, 569, 392, 200.
- Constants are a synthesised case on a 3-bit count, not a RAM.
- FSM IDLE:
  - Accepted sample with dstrb=1: start vector; count<-1; -> ACC.
  - Accepted sample with dstrb=0: ignored; err pulses.
- FSM ACC:
  - Accepted sample with dstrb=0: count<-count+1.
  - Accepted sample with dstrb=1: abort the partial vector, restart with this sample as F(0); count<-1; err pulses; no output for the aborted vector.
  - When the 8th sample (count=7) is accepted: -> IDLE, count<-0.
- busy = (state==ACC).
- Pipeline, with E0 = the edge accepting the sample:
  - S1 at E0: prod = din*c(u), 24-bit signed, registered with a first flag and a last flag.
  - S2 at E0+1: acc (27-bit signed) <- prod if first, else acc+prod.
  - S3 at E0+2, if last: dout <- sat((acc + 1024) >>> 11) to [-2048, 2047]; dout_vld=1 for that cycle.
- Latency: 8th-sample accept edge to dout_vld edge = 2 enabled cycles. Throughput: one vector per 8 enabled cycles. Back-to-back vectors are legal with no bubble.
- dout holds its last value between pulses.
- Shifts are arithmetic, so negatives round toward -inf after the +1024 bias.
- din_vld=0 cycles inside a vector are legal gaps; count does not advance.

Test Plan:
- Reset, then X=0, vector F=(64,0,0,0,0,0,0,0) back-to-back -> acc=46336, dout=23, dout_vld one cycle exactly 2 cycles after the 8th accept, busy high for cycles 1..7.
- X=0, F(0)=-64, rest 0 -> dout=-23.
- X=0, all F=2047 -> dout=2047 (saturated). All F=-2048 -> dout=-2048.
- X=0, F=(64,0,...) with din_vld gaps of 3 cycles and ena toggled low mid-vector -> same dout=23; outputs frozen while ena=0.
- dstrb reasserted at sample 5 followed by a full new vector F=(0,64,0,...) -> err pulse at the restart, single dout_vld with dout=round(64*1004/2048)=31. din_vld without dstrb in IDLE -> err pulse, no state change.
- rst asserted asynchronously mid-vector and mid-S3 -> outputs 0 immediately, no dout_vld; the next full vector gives the correct result.
